// File: rtl/spi_rx_fill.sv
// SPI mode-0 receive engine: clocks bytes in MSB first and writes them one at a
// time into the receive buffer's byte-wide write port, addresses 0..Length.
//
// state   | meaning
// S_IDLE  | waiting for Start; SpiClk low, Busy low
// S_SHIFT | clocking 8 bits in, SpiClk toggling every HalfPeriod cycles
// S_WRITE | one-cycle byte write to the buffer
// S_DONE  | one-cycle Done pulse; a new Start is accepted here too
module spi_rx_fill #(
  parameter int HalfPeriod = 2
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Start,
  input  logic [8:0] Length,
  input  logic       Abort,
  output logic       Busy,
  output logic       Done,
  output logic [9:0] ByteCount,
  output logic       SpiClk,
  output logic       SpiCopi,
  input  logic       SpiCipo,
  output logic       WriteEnable,
  output logic [8:0] WriteAddr,
  output logic [7:0] WriteData
);

  localparam int CW = (HalfPeriod > 1) ? $clog2(HalfPeriod) : 1;
  localparam logic [CW-1:0] HP_LOAD = CW'(HalfPeriod - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] half_q, half_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [8:0]    len_q, len_d;
  logic [8:0]    idx_q, idx_d;
  logic [9:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          sclk_q, sclk_d;
  logic          copi_q, copi_d;
  logic          we_q, we_d;
  logic [8:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      half_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    copi_d  = 1'b1;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    if (Abort) begin
      // Partial byte is dropped; ByteCount and the last write's addr/data hold.
      state_d = S_IDLE;
      busy_d  = 1'b0;
      sclk_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state_d = S_SHIFT;
            len_d   = Length;
            idx_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            half_d  = HP_LOAD;
            bit_d   = '0;
            sclk_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SHIFT: begin
          if (half_q != '0) begin
            half_d = half_q - 1'b1;
          end else begin
            half_d = HP_LOAD;
            if (!sclk_q) begin
              sclk_d  = 1'b1;
              shift_d = {shift_q[6:0], SpiCipo};
            end else begin
              sclk_d = 1'b0;
              if (bit_q == 3'd7) begin
                state_d = S_WRITE;
                we_d    = 1'b1;
                addr_d  = idx_q;
                data_d  = shift_q;
                cnt_d   = cnt_q + 10'd1;
              end else begin
                bit_d = bit_q + 3'd1;
              end
            end
          end
        end
        S_WRITE: begin
          if (idx_q == len_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_SHIFT;
            idx_d   = idx_q + 9'd1;
            half_d  = HP_LOAD;
            bit_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign ByteCount   = cnt_q;
  assign SpiClk      = sclk_q;
  assign SpiCopi     = copi_q;
  assign WriteEnable = we_q;
  assign WriteAddr   = addr_q;
  assign WriteData   = data_q;

endmodule

// File: tb/tb_spi_rx_fill.sv
// Bench for spi_rx_fill: two instances (HalfPeriod 2 and 1) fed by a byte-stream
// peripheral model; expected writes and Done pulses are queued and checked by a monitor.
module tb_spi_rx_fill;

  localparam int B2 = 33;  // 16*2+1
  localparam int B1 = 17;  // 16*1+1

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n;
  logic       start2, abort2, cipo2, busy2, done2, sclk2, copi2, we2;
  logic [8:0] len2, wa2;
  logic [9:0] bc2;
  logic [7:0] wd2;
  logic       start1, abort1, cipo1, busy1, done1, sclk1, copi1, we1;
  logic [8:0] len1, wa1;
  logic [9:0] bc1;
  logic [7:0] wd1;

  spi_rx_fill #(.HalfPeriod(2)) u_h2 (
    .Clk(clk), .nReset(rst_n), .Start(start2), .Length(len2), .Abort(abort2),
    .Busy(busy2), .Done(done2), .ByteCount(bc2), .SpiClk(sclk2), .SpiCopi(copi2),
    .SpiCipo(cipo2), .WriteEnable(we2), .WriteAddr(wa2), .WriteData(wd2)
  );

  spi_rx_fill #(.HalfPeriod(1)) u_h1 (
    .Clk(clk), .nReset(rst_n), .Start(start1), .Length(len1), .Abort(abort1),
    .Busy(busy1), .Done(done1), .ByteCount(bc1), .SpiClk(sclk1), .SpiCopi(copi1),
    .SpiCipo(cipo1), .WriteEnable(we1), .WriteAddr(wa1), .WriteData(wd1)
  );

  typedef struct {int cyc; int addr; int data;} wr_t;
  typedef struct {int cyc; int cnt;} dn_t;

  wr_t wq2[$], wq1[$];
  dn_t dq2[$], dq1[$];
  logic [7:0] tx2[0:2047];
  logic [7:0] tx1[0:2047];
  int k2, b2, k1, b1, pos2;
  logic ps2, ps1;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Peripheral shifts its stream out MSB first, advancing after each SpiClk fall.
  task automatic monitor();
    wr_t w;
    dn_t d;
    forever begin
      @(negedge clk);
      if (we2 === 1'b1) begin
        chk("h2_write_expected", 32'(wq2.size() > 0), 1);
        if (wq2.size() > 0) begin
          w = wq2.pop_front();
          chk("h2_write_cycle", cyc, w.cyc);
          chk("h2_write_addr", 32'(wa2), w.addr);
          chk("h2_write_data", 32'(wd2), w.data);
        end
      end
      if (done2 === 1'b1) begin
        chk("h2_done_expected", 32'(dq2.size() > 0), 1);
        if (dq2.size() > 0) begin
          d = dq2.pop_front();
          chk("h2_done_cycle", cyc, d.cyc);
          chk("h2_done_bytecount", 32'(bc2), d.cnt);
        end
      end
      if (we1 === 1'b1) begin
        chk("h1_write_expected", 32'(wq1.size() > 0), 1);
        if (wq1.size() > 0) begin
          w = wq1.pop_front();
          chk("h1_write_cycle", cyc, w.cyc);
          chk("h1_write_addr", 32'(wa1), w.addr);
          chk("h1_write_data", 32'(wd1), w.data);
        end
      end
      if (done1 === 1'b1) begin
        chk("h1_done_expected", 32'(dq1.size() > 0), 1);
        if (dq1.size() > 0) begin
          d = dq1.pop_front();
          chk("h1_done_cycle", cyc, d.cyc);
          chk("h1_done_bytecount", 32'(bc1), d.cnt);
        end
      end
      if (ps2 === 1'b1 && sclk2 === 1'b0) begin
        b2++;
        if (b2 == 8) begin b2 = 0; k2++; end
      end
      ps2 = sclk2;
      cipo2 = tx2[k2[10:0]][3'(7 - b2)];
      if (ps1 === 1'b1 && sclk1 === 1'b0) begin
        b1++;
        if (b1 == 8) begin b1 = 0; k1++; end
      end
      ps1 = sclk1;
      cipo1 = tx1[k1[10:0]][3'(7 - b1)];
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Queue the expected writes (first nwr bytes) and optional Done for a transfer from e0.
  task automatic push2(input int e0, input int len, input int nwr, input bit with_done);
    wr_t w;
    dn_t d;
    for (int i = 0; i < nwr; i++) begin
      w.cyc = e0 + i * B2 + 32;
      w.addr = i;
      w.data = int'(tx2[(pos2 + i) % 2048]);
      wq2.push_back(w);
    end
    if (with_done) begin
      d.cyc = e0 + (len + 1) * B2;
      d.cnt = len + 1;
      dq2.push_back(d);
    end
    pos2 += len + 1;
  endtask

  task automatic start2_xfer(input int len, input int nwr, input bit with_done, output int e0);
    len2 = 9'(len);
    start2 = 1'b1;
    e0 = cyc + 1;
    push2(e0, len, nwr, with_done);
    @(negedge clk);
    start2 = 1'b0;
  endtask

  int e0, e1;

  initial begin
    wr_t w;
    dn_t d;
    rst_n = 1'b1;
    start2 = 0; abort2 = 0; len2 = '0;
    start1 = 0; abort1 = 0; len1 = '0;
    for (int i = 0; i < 2048; i++) begin
      tx2[i] = 8'($urandom);
      tx1[i] = 8'(i);
    end
    k2 = 0; b2 = 0; k1 = 0; b1 = 0; pos2 = 0;
    ps2 = 1'b0; ps1 = 1'b0;
    cipo2 = tx2[0][7];
    cipo1 = tx1[0][7];
    fork
      monitor();
    join_none

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy2), 0);
    chk("rst_done", 32'(done2), 0);
    chk("rst_bytecount", 32'(bc2), 0);
    chk("rst_sclk", 32'(sclk2), 0);
    chk("rst_copi", 32'(copi2), 1);
    chk("rst_we", 32'(we2), 0);
    chk("rst_waddr", 32'(wa2), 0);
    chk("rst_wdata", 32'(wd2), 0);
    chk("rst_h1_copi", 32'(copi1), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(busy2), 0);
    chk("post_rst_sclk", 32'(sclk2), 0);

    // Single 0xA5 byte with SpiClk edge timing
    tx2[pos2] = 8'hA5;
    start2_xfer(0, 1, 1'b1, e0);
    chk("t1_busy", 32'(busy2), 1);
    for (int b = 0; b < 8; b++) begin
      wait_cyc(e0 + (2 * b + 1) * 2 - 1);
      chk("t1_sclk_low", 32'(sclk2), 0);
      wait_cyc(e0 + (2 * b + 1) * 2);
      chk("t1_sclk_high", 32'(sclk2), 1);
    end
    wait_cyc(e0 + 33);
    chk("t1_done_busy", 32'(busy2), 0);
    wait_cyc(e0 + 34);
    chk("t1_bytecount", 32'(bc2), 1);
    chk("t1_done_cleared", 32'(done2), 0);

    // Start ignored while busy, then Start held through DONE chains a new transfer
    start2_xfer(3, 4, 1'b1, e0);
    wait_cyc(e0 + 40);
    start2 = 1'b1;
    len2 = 9'd0;
    @(negedge clk);
    start2 = 1'b0;
    wait_cyc(e0 + 131);
    start2 = 1'b1;
    len2 = 9'd2;
    e1 = e0 + 133;
    push2(e1, 2, 3, 1'b1);
    wait_cyc(e0 + 132);
    chk("t2_done", 32'(done2), 1);
    chk("t2_done_busy", 32'(busy2), 0);
    wait_cyc(e0 + 133);
    start2 = 1'b0;
    chk("t2_restart_busy", 32'(busy2), 1);
    chk("t2_restart_bytecount", 32'(bc2), 0);
    wait_cyc(e1 + 3 * B2 + 2);
    chk("t2_chain_bytecount", 32'(bc2), 3);
    chk("t2_chain_busy", 32'(busy2), 0);

    // Start and Abort together while idle
    start2 = 1'b1; abort2 = 1'b1; len2 = 9'd5;
    @(negedge clk);
    start2 = 1'b0; abort2 = 1'b0;
    chk("t3_busy", 32'(busy2), 0);
    chk("t3_bytecount_held", 32'(bc2), 3);
    repeat (40) @(negedge clk);
    chk("t3_still_idle", 32'(busy2), 0);
    chk("t3_sclk", 32'(sclk2), 0);

    // Abort in the middle of byte 3 of 8
    start2_xfer(7, 3, 1'b0, e0);
    wait_cyc(e0 + 3 * B2 + 9);
    abort2 = 1'b1;
    wait_cyc(e0 + 3 * B2 + 10);
    abort2 = 1'b0;
    chk("t4_busy", 32'(busy2), 0);
    chk("t4_sclk", 32'(sclk2), 0);
    chk("t4_we", 32'(we2), 0);
    wait_cyc(e0 + 400);
    chk("t4_bytecount", 32'(bc2), 3);
    chk("t4_no_done", 32'(done2), 0);
    chk("t4_writes_drained", wq2.size(), 0);
    b2 = 0; k2 = pos2;

    // 512 bytes at HalfPeriod 1, data i mod 256
    len1 = 9'd511;
    start1 = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i < 512; i++) begin
      w.cyc = e0 + i * B1 + 16;
      w.addr = i;
      w.data = i % 256;
      wq1.push_back(w);
    end
    d.cyc = e0 + 512 * B1;
    d.cnt = 512;
    dq1.push_back(d);
    @(negedge clk);
    start1 = 1'b0;
    wait_cyc(e0 + 512 * B1 + 2);
    chk("t5_bytecount", 32'(bc1), 512);
    chk("t5_busy", 32'(busy1), 0);
    chk("t5_writes_drained", wq1.size(), 0);
    chk("t5_done_seen", dq1.size(), 0);

    // Reset during the WRITE cycle of byte 2
    start2_xfer(7, 2, 1'b0, e0);
    wait_cyc(e0 + 2 * B2 + 31);
    @(posedge clk);
    #1;
    chk("t6_we_presented", 32'(we2), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_we_dropped", 32'(we2), 0);
    chk("t6_busy", 32'(busy2), 0);
    chk("t6_bytecount", 32'(bc2), 0);
    chk("t6_sclk", 32'(sclk2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    b2 = 0; k2 = pos2;
    repeat (300) @(negedge clk);
    chk("t6_idle_busy", 32'(busy2), 0);
    chk("t6_idle_bytecount", 32'(bc2), 0);

    chk("end_h2_writes_drained", wq2.size(), 0);
    chk("end_h2_done_drained", dq2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
